wb_cmd_master: RTL

//  Wishbone classic single-access initiator: the bus-master end of the project-select / config slave.

---
 rtl/wb_cmd_master.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/wb_cmd_master.sv
// ---------------------------------------------------------------------------
// wb_cmd_master
//
// Wishbone classic single-access initiator. Accepts one command at a time on
// a valid/ready port, runs a single WB read or write cycle, and returns the
// read data and status on a valid/ready response port. Only one transaction
// is ever outstanding.
//
// Optional feature (compile-time macro WB_CMD_TIMEOUT_EN):
//   When defined, a 16-bit counter aborts a bus cycle that has gone
//   TIMEOUT_CYCLES cycles without an acknowledge. The aborted cycle reports
//   rsp_err=1 with rsp_dat=RST_DAT. When undefined, the initiator waits for
//   ack indefinitely and rsp_err is tied low.
//
// Parameters:
//   TIMEOUT_CYCLES  cycles cyc/stb may stay high without ack (1..65535)
//   RST_DAT         rsp_dat value after reset, on writes and on timeout
//
// Ports:
//   wb_clk_i, wb_rst_i       clock (rising edge), async active-high reset
//   cmd_valid / cmd_ready    command handshake (cmd_ready = FSM idle)
//   cmd_we/adr/dat/sel       command fields, latched on acceptance
//   rsp_valid / rsp_ready    response handshake
//   rsp_dat, rsp_err         read data / timeout-abort flag
//   busy                     high whenever the FSM is not idle
//   wbm_*                    Wishbone classic master interface
// ---------------------------------------------------------------------------
module wb_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] RST_DAT        = 32'h0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,

  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,

  output logic        busy,

  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Reject an out-of-range timeout at elaboration rather than silently
  // truncating it into the 16-bit counter.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_cmd_master: TIMEOUT_CYCLES must be in 1..65535");
  end

  state_e      state_q;
  logic        cyc_q;
  logic        we_q;
  logic [3:0]  sel_q;
  logic [31:0] adr_q;
  logic [31:0] dat_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_dat_q;
  logic [31:0] rsp_dat_d;

`ifdef WB_CMD_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt_q;
  logic        rsp_err_q;
`endif

  // Writes return the reset pattern; reads return whatever the slave drove
  // alongside its acknowledge.
  assign rsp_dat_d = we_q ? RST_DAT : wbm_dat_i;

  // Single FSM: every output except cmd_ready/busy is a register updated here.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 4'h0;
      adr_q       <= 32'h0;
      dat_q       <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= RST_DAT;
`ifdef WB_CMD_TIMEOUT_EN
      tmo_cnt_q   <= 16'h0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            we_q    <= cmd_we;
            sel_q   <= cmd_sel;
            adr_q   <= cmd_adr;
            dat_q   <= cmd_dat;
            cyc_q   <= 1'b1;
            state_q <= ST_BUS;
`ifdef WB_CMD_TIMEOUT_EN
            tmo_cnt_q <= 16'h0;
`endif
          end
        end

        ST_BUS: begin
          // An ack always wins, even on the edge the timeout would fire.
          if (wbm_ack_i) begin
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_dat_q   <= rsp_dat_d;
            state_q     <= ST_RESP;
`ifdef WB_CMD_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
          end
`ifdef WB_CMD_TIMEOUT_EN
          else if (tmo_cnt_q == TMO_LAST) begin
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_dat_q   <= RST_DAT;
            rsp_err_q   <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
          end
`endif
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);

  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;

`ifdef WB_CMD_TIMEOUT_EN
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule
